// File: rtl/mult_pkg.sv
// Shared types and widths for the 32x32 multiplier arbiter.
//   OP_W / PROD_W : operand and product widths
//   N_REQ         : number of requesters sharing the multiplier
//   arb_state_t   : arbiter FSM states
//   rr_pick       : 2-way round-robin selection, returns a one-hot grant
package mult_pkg;

  localparam int unsigned OP_W   = 32;
  localparam int unsigned PROD_W = 64;
  localparam int unsigned N_REQ  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_HI,
    ST_WAIT_LO,
    ST_RESP
  } arb_state_t;

  // A lone requester wins outright; on contention the one not granted last wins.
  function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] valid,
                                               input logic             last_grant);
    logic [N_REQ-1:0] grant;
    grant = valid;
    if (valid == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end
    return grant;
  endfunction

endpackage

// File: rtl/mult32x32_arbiter.sv
// Shares one 32x32 sequential multiplier between two requesters.
// Round-robin picks a requester, its operands are registered onto the
// multiplier, start is pulsed, busy is tracked (with a timeout on the rising
// edge of busy) and the product is returned over a valid/ready channel.
// Ports:
//   i_clk, i_reset             clock, async active-low reset
//   i_req_valid/o_req_ready    per-requester request handshake
//   i_req_a/i_req_b            per-requester operands, requester k at [32k +: 32]
//   o_rsp_valid/i_rsp_ready    per-requester response handshake
//   o_rsp_product, o_rsp_err   shared response payload (err = start timeout)
//   o_mult_start/a/b           multiplier command
//   i_mult_busy, i_mult_product multiplier status and result
module mult32x32_arbiter
  import mult_pkg::*;
#(
  parameter int unsigned START_TIMEOUT = 8
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [N_REQ-1:0]        i_req_valid,
  input  logic [N_REQ*OP_W-1:0]   i_req_a,
  input  logic [N_REQ*OP_W-1:0]   i_req_b,
  output logic [N_REQ-1:0]        o_req_ready,
  output logic [N_REQ-1:0]        o_rsp_valid,
  input  logic [N_REQ-1:0]        i_rsp_ready,
  output logic [PROD_W-1:0]       o_rsp_product,
  output logic                    o_rsp_err,
  output logic                    o_mult_start,
  output logic [OP_W-1:0]         o_mult_a,
  output logic [OP_W-1:0]         o_mult_b,
  input  logic                    i_mult_busy,
  input  logic [PROD_W-1:0]       i_mult_product
);

  localparam int unsigned CNT_W = $clog2(START_TIMEOUT + 1);

  arb_state_t        r_state;
  logic              r_owner;
  logic              r_last_grant;
  logic [CNT_W-1:0]  r_cnt;
  logic [N_REQ-1:0]  r_rsp_valid;
  logic [PROD_W-1:0] r_rsp_product;
  logic              r_rsp_err;
  logic              r_mult_start;
  logic [OP_W-1:0]   r_mult_a;
  logic [OP_W-1:0]   r_mult_b;

  logic [N_REQ-1:0]  w_grant;
  logic              w_accept;
  logic [N_REQ-1:0]  w_owner_oh;

  assign w_grant    = rr_pick(i_req_valid, r_last_grant);
  assign w_accept   = (r_state == ST_IDLE) && (|w_grant);
  assign w_owner_oh = r_owner ? 2'b10 : 2'b01;

  // Ready is a combinational view of the grant, forced low while reset is held.
  assign o_req_ready = (i_reset && r_state == ST_IDLE) ? w_grant : '0;

  assign o_rsp_valid   = r_rsp_valid;
  assign o_rsp_product = r_rsp_product;
  assign o_rsp_err     = r_rsp_err;
  assign o_mult_start  = r_mult_start;
  assign o_mult_a      = r_mult_a;
  assign o_mult_b      = r_mult_b;

  // Arbiter FSM with registered outputs.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state       <= ST_IDLE;
      r_owner       <= 1'b0;
      r_last_grant  <= 1'b1;
      r_cnt         <= '0;
      r_rsp_valid   <= '0;
      r_rsp_product <= '0;
      r_rsp_err     <= 1'b0;
      r_mult_start  <= 1'b0;
      r_mult_a      <= '0;
      r_mult_b      <= '0;
    end else begin
      r_mult_start <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_owner      <= w_grant[1];
            r_last_grant <= w_grant[1];
            r_mult_a     <= w_grant[1] ? i_req_a[2*OP_W-1:OP_W] : i_req_a[OP_W-1:0];
            r_mult_b     <= w_grant[1] ? i_req_b[2*OP_W-1:OP_W] : i_req_b[OP_W-1:0];
            // Raised here so the pulse is visible for exactly the ISSUE cycle.
            r_mult_start <= 1'b1;
            r_state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_cnt   <= '0;
          r_state <= ST_WAIT_HI;
        end
        ST_WAIT_HI: begin
          if (i_mult_busy) begin
            r_state <= ST_WAIT_LO;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_W'(START_TIMEOUT - 1)) begin
              r_rsp_err     <= 1'b1;
              r_rsp_product <= '0;
              r_rsp_valid   <= w_owner_oh;
              r_state       <= ST_RESP;
            end
          end
        end
        ST_WAIT_LO: begin
          if (!i_mult_busy) begin
            r_rsp_product <= i_mult_product;
            r_rsp_err     <= 1'b0;
            r_rsp_valid   <= w_owner_oh;
            r_state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (i_rsp_ready[r_owner]) begin
            r_rsp_valid <= '0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult32x32_arbiter.sv
// Bench for mult32x32_arbiter: behavioural multiplier, transaction-level
// expectation model, per-cycle compare and directed scenarios with literal
// expected values.
module tb_mult32x32_arbiter;
  import mult_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   req_valid = '0;
  logic [63:0]  req_a = '0;
  logic [63:0]  req_b = '0;
  logic [1:0]   req_ready;
  logic [1:0]   rsp_valid;
  logic [1:0]   rsp_ready = 2'b11;
  logic [63:0]  rsp_product;
  logic         rsp_err;
  logic         mult_start;
  logic [31:0]  mult_a;
  logic [31:0]  mult_b;
  logic         mult_busy;
  logic [63:0]  mult_product;

  int total = 0;
  int bad = 0;

  mult32x32_arbiter #(.START_TIMEOUT(8)) dut (
    .i_clk          (clk),
    .i_reset        (rst_n),
    .i_req_valid    (req_valid),
    .i_req_a        (req_a),
    .i_req_b        (req_b),
    .o_req_ready    (req_ready),
    .o_rsp_valid    (rsp_valid),
    .i_rsp_ready    (rsp_ready),
    .o_rsp_product  (rsp_product),
    .o_rsp_err      (rsp_err),
    .o_mult_start   (mult_start),
    .o_mult_a       (mult_a),
    .o_mult_b       (mult_b),
    .i_mult_busy    (mult_busy),
    .i_mult_product (mult_product)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Multiplier: busy for 4 cycles after a sampled start, product lands as busy drops.
  bit          tmo_mode = 1'b0;
  int          mcnt = 0;
  logic [63:0] mpend = '0;
  assign mult_busy = (mcnt != 0);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcnt         <= 0;
      mult_product <= '0;
    end else if (mult_start && !tmo_mode) begin
      mcnt         <= 4;
      mpend        <= 64'(mult_a) * 64'(mult_b);
      mult_product <= 64'hDEAD_BEEF_0BAD_F00D;
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) mult_product <= mpend;
    end
  end

  // Expectation model: one operation in flight, latency from the accept edge.
  int          cyc = 0;
  bit          m_busy = 1'b0;
  bit          m_owner = 1'b0;
  bit          m_last = 1'b1;
  bit          m_err = 1'b0;
  int          m_start_at = 0;
  int          m_rsp_at = 0;
  logic [63:0] m_prod = '0;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;

  function automatic logic [1:0] exp_grant(input logic [1:0] v, input bit last);
    if (v == 2'b11) return last ? 2'b01 : 2'b10;
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_last = 1'b1;
      m_a    = '0;
      m_b    = '0;
    end else begin
      cyc++;
      if (!m_busy) begin
        if (req_valid != 2'b00) begin
          m_owner    = exp_grant(req_valid, m_last) == 2'b10;
          m_last     = m_owner;
          m_busy     = 1'b1;
          m_a        = m_owner ? req_a[63:32] : req_a[31:0];
          m_b        = m_owner ? req_b[63:32] : req_b[31:0];
          m_prod     = tmo_mode ? 64'd0 : 64'(m_a) * 64'(m_b);
          m_err      = tmo_mode;
          m_start_at = cyc;
          m_rsp_at   = cyc + (tmo_mode ? 9 : 6);
        end
      end else if (cyc - 1 >= m_rsp_at && rsp_ready[m_owner]) begin
        m_busy = 1'b0;
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    logic [1:0] ev;
    if (!rst_n) begin
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_mult_start", 64'(mult_start), 64'd0);
    end else begin
      ev = (m_busy && cyc >= m_rsp_at) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
      check("mon_req_ready", 64'(req_ready), 64'(m_busy ? 2'b00 : exp_grant(req_valid, m_last)));
      check("mon_mult_start", 64'(mult_start), 64'(m_busy && cyc == m_start_at));
      check("mon_rsp_valid", 64'(rsp_valid), 64'(ev));
      check("mon_mult_a", 64'(mult_a), 64'(m_a));
      check("mon_mult_b", 64'(mult_b), 64'(m_b));
      if (ev != 2'b00) begin
        check("mon_rsp_product", rsp_product, m_prod);
        check("mon_rsp_err", 64'(rsp_err), 64'(m_err));
      end
    end
  end

  task automatic drive_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int idx, input logic [31:0] a, input logic [31:0] b);
    if (idx == 0) begin req_a[31:0] = a; req_b[31:0] = b; end
    else          begin req_a[63:32] = a; req_b[63:32] = b; end
  endtask

  task automatic wait_ready(input int idx);
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready[idx]) begin ok = 1'b1; break; end
    end
    check("ready_wait", 64'(ok), 64'd1);
  endtask

  task automatic wait_rsp(input int idx);
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rsp_valid[idx]) begin ok = 1'b1; break; end
    end
    check("rsp_wait", 64'(ok), 64'd1);
  endtask

  // Single operation with literal latency (negedges from ready to rsp_valid).
  task automatic op(input int idx, input logic [31:0] a, input logic [31:0] b,
                    input int exp_lat, input logic [63:0] exp_prod, input bit exp_err);
    int  lat = 0;
    bit  ok = 1'b0;
    drive_step();
    set_ops(idx, a, b);
    req_valid[idx] = 1'b1;
    wait_ready(idx);
    drive_step();
    req_valid[idx] = 1'b0;
    for (int i = 1; i < 50; i++) begin
      @(negedge clk);
      if (i == 1) check("op_start_pulse", 64'(mult_start), 64'd1);
      if (rsp_valid[idx]) begin lat = i; ok = 1'b1; break; end
    end
    check("op_rsp_seen", 64'(ok), 64'd1);
    check("op_latency", 64'(lat), 64'(exp_lat));
    check("op_product", rsp_product, exp_prod);
    check("op_err", 64'(rsp_err), 64'(exp_err));
  endtask

  task automatic pulse_reset();
    drive_step();
    rst_n = 1'b0;
    drive_step();
    rst_n = 1'b1;
  endtask

  initial begin
    int          who;
    logic [63:0] prod;

    // Reset state
    #12;
    check("reset_req_ready", 64'(req_ready), 64'd0);
    check("reset_mult_a", 64'(mult_a), 64'd0);
    check("reset_product", rsp_product, 64'd0);
    check("reset_err", 64'(rsp_err), 64'd0);
    drive_step();
    rst_n = 1'b1;

    // Single request and max operands
    op(0, 32'h0000_0003, 32'h0000_0005, 7, 64'd15, 1'b0);
    op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 7, 64'hFFFF_FFFE_0000_0001, 1'b0);

    // Contention from reset, both held: alternates 0,1,0,1
    pulse_reset();
    set_ops(0, 32'd2, 32'd3);
    set_ops(1, 32'd4, 32'd5);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      bit ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (rsp_valid != 2'b00) begin ok = 1'b1; break; end
      end
      check("cont_rsp_seen", 64'(ok), 64'd1);
      who  = rsp_valid[1] ? 1 : 0;
      prod = rsp_product;
      check("cont_owner", 64'(who), 64'(k % 2));
      check("cont_product", prod, (k % 2 == 0) ? 64'd6 : 64'd20);
      drive_step();
      if (k == 3) req_valid = 2'b00;
    end

    // Backpressure on owner 0; non-owner rsp_ready is ignored; req1 waits
    drive_step();
    rsp_ready = 2'b10;
    set_ops(0, 32'd10, 32'd10);
    req_valid = 2'b01;
    wait_ready(0);
    drive_step();
    set_ops(1, 32'd3, 32'd7);
    req_valid = 2'b10;
    wait_rsp(0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("bp_rsp_valid", 64'(rsp_valid), 64'(2'b01));
      check("bp_product", rsp_product, 64'd100);
      check("bp_req_ready", 64'(req_ready), 64'd0);
    end
    drive_step();
    rsp_ready = 2'b11;
    @(negedge clk);
    check("bp_hold_before_hs", 64'(req_ready), 64'd0);
    @(negedge clk);
    check("bp_ready_after_hs", 64'(req_ready), 64'(2'b10));
    check("bp_rsp_cleared", 64'(rsp_valid), 64'd0);
    drive_step();
    req_valid = 2'b00;
    wait_rsp(1);
    check("bp_req1_product", rsp_product, 64'd21);
    drive_step();

    // Start timeout: busy never rises
    tmo_mode = 1'b1;
    op(0, 32'd9, 32'd9, 10, 64'd0, 1'b1);
    drive_step();
    tmo_mode = 1'b0;

    // Reset during WAIT_LO, then a fresh operation
    drive_step();
    set_ops(1, 32'd11, 32'd13);
    req_valid = 2'b10;
    wait_ready(1);
    drive_step();
    req_valid = 2'b00;
    for (int i = 0; i < 4; i++) @(negedge clk);
    check("mid_busy_before_reset", 64'(mult_busy), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst_mult_start", 64'(mult_start), 64'd0);
    check("mid_rst_mult_a", 64'(mult_a), 64'd0);
    check("mid_rst_mult_b", 64'(mult_b), 64'd0);
    check("mid_rst_product", rsp_product, 64'd0);
    check("mid_rst_err", 64'(rsp_err), 64'd0);
    drive_step();
    rst_n = 1'b1;
    op(0, 32'd7, 32'd6, 7, 64'd42, 1'b0);
    drive_step();
    drive_step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mult32x32_arbiter.md
Name: mult32x32_arbiter

Overview:
- Shares one 32x32 sequential multiplier (start/busy handshake, 64-bit product register) between two requesters.
- Arbitration is round-robin. The block registers the winner's operands, pulses start, tracks busy and captures the product.
- It returns the product to the owning requester over a valid/ready response channel.
- Sits between requester-side logic and the multiplier top level; it is the only agent that drives the multiplier's start.

Parameters:
- START_TIMEOUT, 8, cycles to wait for mult_busy to rise after a start pulse before flagging an error.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- req_valid  in  2  per-requester request valid; index 0 / 1
- req_a  in  2x32  per-requester operand A
- req_b  in  2x32  per-requester operand B
- req_ready  out  2  per-requester accept; at most one bit set
- rsp_valid  out  2  per-requester response valid; at most one bit set
- rsp_ready  in  2  per-requester response accept
- rsp_product  out  64  captured product, shared by both responders
- rsp_err  out  1  qualifies rsp_product as invalid (timeout); valid only with rsp_valid
- mult_start  out  1  one-cycle start pulse to multiplier
- mult_a  out  32  registered operand A to multiplier
- mult_b  out  32  registered operand B to multiplier
- mult_busy  in  1  multiplier busy
- mult_product  in  64  multiplier product register

Behaviour:
- Reset values (reset=0, asynchronous):
  - state=IDLE
  - req_ready=0, rsp_valid=0, mult_start=0, rsp_err=0
  - mult_a=0, mult_b=0, rsp_product=0
  - timeout counter=0
  - last_grant=1, so requester 0 wins the first contention.
- States: IDLE, ISSUE, WAIT_HI, WAIT_LO, RESP.
- IDLE:
  - req_ready is combinational: the grant bit is set when the selected req_valid is 1.
  - Selection: if only one req_valid is set, that requester wins. If both are set, the requester != last_grant wins.
  - On accept: latch req_a/req_b into mult_a/mult_b, record owner, set last_grant=owner, go to ISSUE.
  - With no valid request, stay in IDLE.
- ISSUE: mult_start=1 for exactly this cycle; clear counter; go to WAIT_HI.
- WAIT_HI:
  - If mult_busy=1, go to WAIT_LO.
  - Otherwise increment the counter. On reaching START_TIMEOUT: set rsp_err=1, rsp_product=0, go to RESP.
- WAIT_LO: on mult_busy=0, capture mult_product into rsp_product, set rsp_err=0, go to RESP.
- RESP:
  - rsp_valid[owner]=1, held until rsp_ready[owner]=1, then go to IDLE.
  - rsp_ready of the non-owner is ignored.
  - No new request is accepted until the cycle after the response handshake.
- Latency, for a multiplier with busy high 4 cycles starting the cycle after start:
  - Accept edge at T0; mult_start at T1; busy T2-T5; capture at T6; rsp_valid at T7.
  - Back-to-back throughput is one operation per 8 cycles with rsp_ready held high.
- mult_a/mult_b hold their value from accept until the next accept; they are unchanged through RESP.
- Simultaneous events:
  - req_valid may drop without ready; nothing is latched in that case.
  - A requester holding req_valid while its own response is pending is not served until RESP completes.
- Reset mid-operation: all state returns to reset values immediately. A start pulse in flight is abandoned, and the multiplier's own reset is responsible for it.

Decomposition:
- Shared package mult_pkg holds:
  - state enum arb_state_t
  - localparams for operand width 32 and product width 64
  - N_REQ = 2
- One natural sub-module: mult_rr_arbiter2, the 2-way round-robin picker (inputs req_valid, last_grant; output one-hot grant).
  - It is combinational, so it is optional; it is inlined if it stays under 20 lines.

Test Plan:
- Single request: req0 a=0x0000_0003 b=0x0000_0005 -> req_ready[0] at T0, mult_start at T1, rsp_valid[0] at T7, rsp_product=15, rsp_err=0.
- Max operands: req1 a=b=0xFFFF_FFFF -> rsp_product=0xFFFF_FFFE_0000_0001 on rsp_valid[1].
- Contention: both valid from reset with ops (2,3) and (4,5) -> req0 served first (6), then req1 (20). Repeat with both valid -> order alternates 1,0.
- Backpressure: hold rsp_ready[0]=0 for 5 cycles -> rsp_valid[0] and rsp_product stable; req1 is not accepted until one cycle after the handshake.
- Timeout: model multiplier never raises busy, START_TIMEOUT=8 -> rsp_valid with rsp_err=1, rsp_product=0, 8 cycles after WAIT_HI entry.
- Reset mid-op: drive reset=0 during WAIT_LO -> all outputs zero asynchronously. After release, a new req0 (7,6) completes with 42.
